// File: rtl/std_sram_singleport_ctrl_pkg.sv
// Shared definitions for the single-port SRAM request front-end.
//   state_t        : controller FSM states (INIT zero-fill, RUN normal service)
//   RSPQ_*         : response queue depth, pointer width and occupancy type
//   credit_ok()    : read admission test against queue space plus reads in flight
package std_sram_singleport_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RSPQ_DEPTH     = 4;
  localparam int RSPQ_PTR_WIDTH = 2;
  localparam int RSPQ_CNT_WIDTH = RSPQ_PTR_WIDTH + 1;

  typedef logic [RSPQ_CNT_WIDTH-1:0] rspq_cnt_t;

  localparam rspq_cnt_t RSPQ_FULL = rspq_cnt_t'(RSPQ_DEPTH);

  // Every read already issued will land in the queue, so it reserves a slot
  // from the moment it is granted.
  function automatic logic credit_ok(input rspq_cnt_t cnt, input logic p1, input logic p2);
    return (cnt + rspq_cnt_t'(p1) + rspq_cnt_t'(p2)) < RSPQ_FULL;
  endfunction

endpackage

// File: rtl/srd_sram_singleport_dffran.sv
// Behavioural single-port SRAM macro wrapper with a registered read path.
// A read (en=1, we=0) latches the array word into an internal register at the
// end of the issue cycle; the output DFF loads that register only on a cycle
// that again has en=1, we=0, so the word reaches dout two cycles after issue.
// Ports:
//   clk          clock
//   en, we       port enable and write enable
//   addr, din    word address and write data
//   dout         registered read data
module srd_sram_singleport_dffran #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] word_q;

  always_ff @(posedge clk) begin
    if (en & we) mem[addr] <= din;
    if (en & ~we) begin
      word_q <= mem[addr];
      dout   <= word_q;
    end
  end

endmodule

// File: rtl/std_sram_ctrl_rspq.sv
// Read response queue: 4-entry synchronous FIFO with registered storage.
// Ports:
//   clk, resetn           clock, synchronous active-low reset (pointers/count only)
//   push, push_data       write one word when push=1 (accepted while full if popping)
//   pop                   consume head word when pop=1 and queue non-empty
//   pop_data, valid       head word and non-empty flag
//   count                 current occupancy 0..4
module std_sram_ctrl_rspq
  import std_sram_singleport_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  valid,
  output rspq_cnt_t             count
);

  logic [DATA_WIDTH-1:0]     mem [RSPQ_DEPTH];
  logic [RSPQ_PTR_WIDTH-1:0] wptr;
  logic [RSPQ_PTR_WIDTH-1:0] rptr;
  rspq_cnt_t                 cnt;
  logic                      full;
  logic                      empty;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (cnt == RSPQ_FULL);
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  assign pop_data = mem[rptr];
  assign valid    = ~empty;
  assign count    = cnt;

endmodule

// File: rtl/std_sram_singleport_ctrl.sv
// Request front-end for srd_sram_singleport_dffran.
// Arbitrates independent write and read valid/ready streams onto the single
// SRAM port, tracks the two-cycle registered read latency and returns read
// data in request order through a 4-entry response queue.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data write request stream
//   rd_valid/rd_ready/rd_addr         read request stream
//   rsp_valid/rsp_ready/rsp_data      in-order read response stream
//   busy                              reads in flight, queue non-empty or zero-fill active
// Build option: define STD_SRAM_CTRL_ZEROINIT_EN to zero-fill the whole array
// after every reset before any request is accepted.
module std_sram_singleport_ctrl
  import std_sram_singleport_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  state_t                state;
  state_t                state_nxt;
  logic                  run;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_last;

  logic                  rd_p1;
  logic                  rd_p2;
  logic [ADDR_WIDTH-1:0] rd_addr_p1;
  logic                  ptr_wr;

  logic                  rd_elig;
  logic                  wr_legal;
  logic                  contested;
  logic                  rd_go;
  logic                  wr_go;

  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  rspq_cnt_t             q_count;

`ifdef STD_SRAM_CTRL_ZEROINIT_EN
  localparam state_t RST_STATE = ST_INIT;

  always_ff @(posedge clk) begin
    if (!resetn)              init_addr <= '0;
    else if (state == ST_INIT) init_addr <= init_addr + 1'b1;
  end

  assign init_last = (init_addr == '1);
`else
  localparam state_t RST_STATE = ST_RUN;

  assign init_addr = '0;
  assign init_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= RST_STATE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_last) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = RST_STATE;
    endcase
  end

  // Requests are refused while reset is held so nothing is handshaken into a
  // cycle whose effects the reset edge is about to discard.
  always_comb begin
    run     = 1'b0;
    init_wr = 1'b0;
    case (state)
      ST_INIT: init_wr = resetn;
      ST_RUN:  run     = resetn;
      default: ;
    endcase
  end

  // A write in the cycle after a read grant would steal the capture cycle that
  // the SRAM output DFF needs, so writes are illegal whenever rd_p1 is set.
  // When both sides ask, the pointer picks; a write winner that is illegal
  // leaves the cycle as a pure capture cycle.
  assign rd_elig   = run & credit_ok(q_count, rd_p1, rd_p2);
  assign wr_legal  = run & ~rd_p1;
  assign contested = rd_valid & rd_elig & wr_valid;
  assign rd_ready  = rd_elig  & ~(contested &  ptr_wr);
  assign wr_ready  = wr_legal & ~(contested & ~ptr_wr);
  assign rd_go     = rd_valid & rd_ready;
  assign wr_go     = wr_valid & wr_ready;

  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = rd_addr_p1;
    sram_din  = wr_data;
    if (init_wr) begin
      sram_en   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = init_addr;
      sram_din  = '0;
    end else if (rd_go) begin
      sram_en   = 1'b1;
      sram_addr = rd_addr;
    end else if (wr_go) begin
      sram_en   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = wr_addr;
    end else if (rd_p1) begin
      sram_en   = 1'b1;
    end
  end

  // Stage p0 -> p1: read issued to the array, word sits in the SRAM register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_p1  <= 1'b0;
      rd_p2  <= 1'b0;
      ptr_wr <= 1'b0;
    end else begin
      rd_p1 <= rd_go;
      rd_p2 <= rd_p1;
      if (contested & (rd_go | wr_go)) ptr_wr <= ~ptr_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_go) rd_addr_p1 <= rd_addr;
  end

  srd_sram_singleport_dffran #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .din  (sram_din),
    .dout (sram_dout)
  );

  // Stage p2 -> queue: word on dout, pushed into the response queue
  std_sram_ctrl_rspq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rspq (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rd_p2),
    .push_data (sram_dout),
    .pop       (rsp_ready),
    .pop_data  (rsp_data),
    .valid     (rsp_valid),
    .count     (q_count)
  );

  assign busy = rd_p1 | rd_p2 | (q_count != '0) | (state == ST_INIT);

endmodule

// File: tb/tb_std_sram_singleport_ctrl.sv
// Scoreboard bench for std_sram_singleport_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8).
module tb_std_sram_singleport_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef STD_SRAM_CTRL_ZEROINIT_EN
  localparam logic BUSY_AFTER_RST = 1'b1;
`else
  localparam logic BUSY_AFTER_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          busy;

  std_sram_singleport_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [16];
  bit            exact_lat = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: cycle %0d", name, cyc);
  endtask

  // Monitor: update the memory model on write handshakes, queue the expected
  // word on read handshakes, compare whenever a response is consumed.
  always @(negedge clk) begin
    if (resetn) begin
      if (wr_valid && wr_ready) model_mem[wr_addr] = wr_data;
      if (rd_valid && rd_ready) exp_q.push_back('{model_mem[rd_addr], cyc});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          if (exact_lat) check("rsp_latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
    end
  end

  task automatic do_reset();
    resetn   = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.delete();
`ifdef STD_SRAM_CTRL_ZEROINIT_EN
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
`endif
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'(BUSY_AFTER_RST));
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w;
    bit ok;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      ok = wr_ready;
      @(posedge clk); #1;
      w++;
    end while (!ok && w < 100);
    wr_valid = 1'b0;
    if (!ok) fail_now("wr_timeout");
  endtask

  task automatic rd(input logic [AW-1:0] a, output int waits);
    int w;
    bit ok;
    rd_addr  = a;
    rd_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      ok = rd_ready;
      @(posedge clk); #1;
      w++;
    end while (!ok && w < 100);
    rd_valid = 1'b0;
    waits = w - 1;
    if (!ok) fail_now("rd_timeout");
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    w;
    int    acc;
    bit    g;
    string pat;
    byte   gch;

    @(posedge clk); #1;
    do_reset();

`ifdef STD_SRAM_CTRL_ZEROINIT_EN
    // Zero-fill: ready held low 16 cycles, then every address reads as zero.
    acc = 1;
    begin
      int n;
      n = 0;
      while (n < 100) begin
        @(negedge clk);
        if (wr_ready) break;
        acc++;
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
    end
    check("init_ready_low_cycles", 32'(acc), 32'd16);
    for (int i = 0; i < 16; i++) rd(AW'(i), w);
    drain("init_reads");
`endif

    // Write then read one word, exact latency.
    wr(4'd3, 8'hA5);
    exact_lat = 1'b1;
    rd(4'd3, w);
    drain("single_read");
    exact_lat = 1'b0;

    // Back-to-back reads of 0..7: accepted every cycle, responses in order.
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(8'h10 + i * 3));
    exact_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(AW'(i), w);
      check("b2b_rd_ready", 32'(w), 32'd0);
    end
    drain("b2b_reads");
    exact_lat = 1'b0;

    // Response back-pressure: only four reads admitted.
    rsp_ready = 1'b0;
    rd_addr   = '0;
    rd_valid  = 1'b1;
    acc       = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g = rd_ready;
      if (g) acc++;
      @(posedge clk); #1;
      if (g) rd_addr = rd_addr + 1'b1;
    end
    check("credit_accepts", 32'(acc), 32'd4);
    @(negedge clk);
    check("credit_stall", 32'(rd_ready), 32'd0);
    @(posedge clk); #1;
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    drain("credit_release");

    // Contested read/write: R, capture, W repeating.
    do_reset();
    wr(4'd10, 8'h55);
    @(posedge clk); #1;
    wr_addr  = 4'd10;
    wr_data  = 8'h60;
    wr_valid = 1'b1;
    rd_addr  = 4'd10;
    rd_valid = 1'b1;
    pat = "R-WR-WR-WR";
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gch = (rd_valid && rd_ready) ? "R" : ((wr_valid && wr_ready) ? "W" : "-");
      check("arb_grant", 32'(gch), 32'(pat[k]));
      @(posedge clk); #1;
      if (gch == "W") wr_data = wr_data + 1'b1;
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    drain("arb_drain");

    // Reset with two reads in flight: nothing comes out afterwards.
    rd(4'd0, w);
    rd(4'd1, w);
    do_reset();
    repeat (10) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    check("no_stale_busy", 32'(busy), 32'd0);
    check("no_stale_q", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
